// File: rtl/program_store_if.sv
// Bus bundle between the CPU fetch/loader side and the program store.
// The store takes the slave view; the fetch unit and loader take the master view.
interface program_store_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
);
  logic [ADDR_W-1:0] address_bus;
  logic [DATA_W-1:0] data_bus;
  logic [DATA_W-1:0] data_bus_next;
  logic              load_start;
  logic              load_valid;
  logic [DATA_W-1:0] load_data;
  logic              load_last;
  logic              load_ready;
  logic              loading;
  logic              load_done;
  logic              load_error;
  logic [ADDR_W:0]   load_count;
  logic [DATA_W-1:0] checksum;

  modport master (
    output address_bus, load_start, load_valid, load_data, load_last,
    input  data_bus, data_bus_next, load_ready, loading, load_done,
           load_error, load_count, checksum
  );

  modport slave (
    input  address_bus, load_start, load_valid, load_data, load_last,
    output data_bus, data_bus_next, load_ready, loading, load_done,
           load_error, load_count, checksum
  );
endinterface

// File: rtl/program_store.sv
// Program memory with a streaming loader. It serves two-word combinational
// fetches and accepts a program image word by word while fetch returns NOPs.
module program_store #(
  parameter int              ADDR_W   = 8,
  parameter int              DATA_W   = 8,
  parameter logic [DATA_W-1:0] NOP_WORD = DATA_W'(8'h70)
) (
  input  logic           clk,
  input  logic           reset,
  program_store_if.slave bus
);
  localparam int DEPTH = 2 ** ADDR_W;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t            state, state_next;
  logic [ADDR_W:0]   load_count_q;
  logic [DATA_W-1:0] checksum_q;
  logic              load_error_q;
  logic              full;
  logic              accept;
  logic              overflow;
  logic [ADDR_W-1:0] address_next;

  logic [DATA_W-1:0] mem [DEPTH];

  // The count never exceeds DEPTH, so its top bit alone means "array full".
  assign full     = load_count_q[ADDR_W];
  assign accept   = (state == LOAD) && !full && bus.load_valid && !bus.load_start;
  assign overflow = (state == LOAD) &&  full && bus.load_valid && !bus.load_start;

  always_comb begin
    // NOTE: the default is assigned first so no path through the case infers a latch.
    state_next = state;
    if (bus.load_start) begin
      state_next = LOAD;
    end else begin
      case (state)
        IDLE: state_next = IDLE;
        LOAD: begin
          if (overflow)                      state_next = IDLE;
          else if (accept && bus.load_last)  state_next = DONE;
        end
        DONE:    state_next = IDLE;
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      load_count_q <= '0;
      checksum_q   <= '0;
      load_error_q <= 1'b0;
    end else begin
      state <= state_next;
      // A restart discards whatever word is presented in the same cycle.
      if (bus.load_start) begin
        load_count_q <= '0;
        checksum_q   <= '0;
        load_error_q <= 1'b0;
      end else begin
        if (accept) begin
          load_count_q <= load_count_q + (ADDR_W+1)'(1);
          checksum_q   <= checksum_q + bus.load_data;
        end
        if (overflow) load_error_q <= 1'b1;
      end
    end
  end

  // NOTE: the array has no reset; a reset mid-load keeps every word already written.
  always_ff @(posedge clk) begin
    if (accept) mem[load_count_q[ADDR_W-1:0]] <= bus.load_data;
  end

  assign address_next      = bus.address_bus + ADDR_W'(1);
  assign bus.load_ready    = (state == LOAD) && !full;
  assign bus.loading       = (state == LOAD);
  assign bus.load_done     = (state == DONE);
  assign bus.load_error    = load_error_q;
  assign bus.load_count    = load_count_q;
  assign bus.checksum      = checksum_q;
  assign bus.data_bus      = bus.loading ? NOP_WORD : mem[bus.address_bus];
  assign bus.data_bus_next = bus.loading ? NOP_WORD : mem[address_next];
endmodule

// File: tb/tb_program_store.sv
// Self-checking bench for program_store: a reference image tracks every
// accepted word, and loaded words queue up for readback once the load ends.
module tb_program_store;
  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  typedef struct {
    logic [7:0] addr;
    logic [7:0] data;
  } sb_t;

  sb_t        sb_q[$];
  logic [7:0] ref_mem [256];
  int         ref_count;
  logic [7:0] ref_sum;

  program_store_if #(.ADDR_W(8), .DATA_W(8)) bus ();

  program_store #(.ADDR_W(8), .DATA_W(8), .NOP_WORD(8'h70)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_status(input string tag, input logic lo, input logic rd,
                              input logic dn, input logic er);
    check({tag, ".loading"},    32'(bus.loading),    32'(lo));
    check({tag, ".load_ready"}, 32'(bus.load_ready), 32'(rd));
    check({tag, ".load_done"},  32'(bus.load_done),  32'(dn));
    check({tag, ".load_error"}, 32'(bus.load_error), 32'(er));
    check({tag, ".load_count"}, 32'(bus.load_count), 32'(ref_count));
    check({tag, ".checksum"},   32'(bus.checksum),   32'(ref_sum));
  endtask

  task automatic start_load();
    bus.load_start = 1'b1;
    tick();
    bus.load_start = 1'b0;
    ref_count = 0;
    ref_sum   = 8'h00;
    sb_q.delete();
  endtask

  task automatic send(input logic [7:0] d, input logic last);
    bus.load_valid = 1'b1;
    bus.load_data  = d;
    bus.load_last  = last;
    ref_mem[8'(ref_count)] = d;
    sb_q.push_back('{addr: 8'(ref_count), data: d});
    ref_count++;
    ref_sum += d;
    tick();
    bus.load_valid = 1'b0;
    bus.load_last  = 1'b0;
  endtask

  task automatic fetch(input string tag, input logic [7:0] addr,
                       input logic [7:0] exp_db, input logic [7:0] exp_next);
    bus.address_bus = addr;
    #1;
    check({tag, ".data_bus"},      32'(bus.data_bus),      32'(exp_db));
    check({tag, ".data_bus_next"}, 32'(bus.data_bus_next), 32'(exp_next));
  endtask

  task automatic drain_readback(input string tag);
    sb_t e;
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      bus.address_bus = e.addr;
      #1;
      check($sformatf("%s[%0d]", tag, e.addr), 32'(bus.data_bus), 32'(e.data));
    end
  endtask

  logic [7:0] image [13] = '{8'h80, 8'h20, 8'h98, 8'h99, 8'h8D, 8'h00, 8'hB4,
                             8'h0C, 8'h02, 8'h95, 8'hA8, 8'h04, 8'h9E};

  initial begin
    reset           = 1'b0;
    bus.address_bus = '0;
    bus.load_start  = 1'b0;
    bus.load_valid  = 1'b0;
    bus.load_data   = '0;
    bus.load_last   = 1'b0;
    ref_count       = 0;
    ref_sum         = 8'h00;

    // Reset state, and reset release must not start a load.
    #3;
    check_status("reset", 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    reset = 1'b1;
    tick();
    check_status("post_reset", 1'b0, 1'b0, 1'b0, 1'b0);

    // 13-word image; these words sum to 0xFF mod 256.
    start_load();
    check_status("img_start", 1'b1, 1'b1, 1'b0, 1'b0);
    foreach (image[i]) send(image[i], i == 12);
    check_status("img_done", 1'b0, 1'b0, 1'b1, 1'b0);
    check("img_sum_const", 32'(bus.checksum), 32'h0000_00FF);
    tick();
    check_status("img_idle", 1'b0, 1'b0, 1'b0, 1'b0);
    fetch("img_addr4", 8'd4, 8'h8D, 8'h00);
    drain_readback("img_rb");

    // load_valid toggling; fetch returns NOP while loading.
    start_load();
    bus.address_bus = 8'd0;
    for (int i = 0; i <= 8; i++) begin
      if (i % 2 == 0) begin
        send(8'(8'h30 + i), i == 8);
      end else begin
        bus.load_data = 8'hFF;
        tick();
      end
      if (i == 3) fetch("nop_fetch", 8'd0, 8'h70, 8'h70);
    end
    check_status("toggle_done", 1'b0, 1'b0, 1'b1, 1'b0);
    check("toggle_count_const", 32'(bus.load_count), 32'd5);
    tick();
    drain_readback("toggle_rb");

    // Restart after 5 words collides with a 6th valid word.
    start_load();
    for (int i = 0; i < 5; i++) send(8'(8'h11 + i), 1'b0);
    bus.load_start = 1'b1;
    bus.load_valid = 1'b1;
    bus.load_data  = 8'hEE;
    tick();
    bus.load_start = 1'b0;
    bus.load_valid = 1'b0;
    ref_count = 0;
    ref_sum   = 8'h00;
    sb_q.delete();
    check_status("restart", 1'b1, 1'b1, 1'b0, 1'b0);
    send(8'h21, 1'b0);
    send(8'h22, 1'b1);
    check_status("restart_done", 1'b0, 1'b0, 1'b1, 1'b0);
    tick();
    drain_readback("restart_rb");
    fetch("restart_addr3", 8'd3, 8'h14, 8'h15);
    fetch("restart_addr5", 8'd5, ref_mem[5], ref_mem[6]);

    // Exactly DEPTH words completes cleanly.
    start_load();
    for (int i = 0; i < 256; i++) begin
      if (i == 255) check("full_ready_255", 32'(bus.load_ready), 32'd1);
      send(8'h01, i == 255);
    end
    check_status("full_done", 1'b0, 1'b0, 1'b1, 1'b0);
    tick();

    // DEPTH words without last, then one more valid -> overflow.
    start_load();
    for (int i = 0; i < 256; i++) send(8'(i) ^ 8'h5A, 1'b0);
    check_status("ovf_full", 1'b1, 1'b0, 1'b0, 1'b0);
    bus.load_valid = 1'b1;
    bus.load_data  = 8'hFF;
    tick();
    bus.load_valid = 1'b0;
    check_status("ovf_err", 1'b0, 1'b0, 1'b0, 1'b1);
    tick();
    check_status("ovf_sticky", 1'b0, 1'b0, 1'b0, 1'b1);
    drain_readback("ovf_rb");
    fetch("ovf_wrap", 8'hFF, ref_mem[255], ref_mem[0]);
    start_load();
    check_status("ovf_clear", 1'b1, 1'b1, 1'b0, 1'b0);

    // Asynchronous reset after 3 accepted words.
    send(8'hA1, 1'b0);
    send(8'hB2, 1'b0);
    send(8'hC3, 1'b0);
    #2;
    reset = 1'b0;
    #1;
    ref_count = 0;
    ref_sum   = 8'h00;
    check_status("async_reset", 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    reset = 1'b1;
    tick();
    check_status("reset_idle", 1'b0, 1'b0, 1'b0, 1'b0);
    drain_readback("reset_rb");
    fetch("reset_wrap", 8'hFF, ref_mem[255], 8'hA1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
